// File: rtl/antilog2_pkg.sv
// antilog2_pkg: shared widths, stage record and width helpers for the antilog2 pipeline
package antilog2_pkg;
  localparam int STAGES = 3;
  localparam int OUT_W = 8;
  localparam int FRAC_BITS_DEF = 8;
  localparam int LOG_W = 3 + FRAC_BITS_DEF;
  localparam int DP_W = FRAC_BITS_DEF + 8;
  typedef struct packed {
    logic            valid;
    logic [DP_W-1:0] mant;
    logic [1:0]      exp_rem;
  } stage_t;
  function automatic int log_w(input int fb);
    return 3 + fb;
  endfunction
  function automatic int dp_w(input int fb);
    return fb + OUT_W;
  endfunction
endpackage

// File: rtl/antilog2_shift_stage.sv
// antilog2_shift_stage: one conditional left-shift pipeline register with stall enable and optional truncation
module antilog2_shift_stage
  import antilog2_pkg::*;
#(
  parameter int IW = DP_W,
  parameter int OW = DP_W,
  parameter int SHIFT = 1,
  parameter int LSB = 0
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          en_i,
  input  logic          v_i,
  input  logic          sel_i,
  input  logic [IW-1:0] mant_i,
  output logic          v_o,
  output logic [OW-1:0] mant_o
);
  logic [IW-1:0] sh;
  logic [OW-1:0] mant_d;
  logic          v_q;
  logic [OW-1:0] mant_q;
  assign sh = sel_i ? mant_i << SHIFT : mant_i;
  assign mant_d = OW'(sh >> LSB);
  assign v_o = v_q;
  assign mant_o = mant_q;
  // valid always follows the enable; data only loads behind a valid word
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      v_q <= 1'b0;
      mant_q <= '0;
    end else if (en_i) begin
      v_q <= v_i;
      if (v_i) mant_q <= mant_d;
    end
endmodule

// File: rtl/antilog2_fixed_point.sv
// antilog2_fixed_point: pipelined Mitchell antilog, Q3.F log2 in, uint8 2^k*(1+f) out over valid/ready
module antilog2_fixed_point
  import antilog2_pkg::*;
#(
  parameter int FRAC_BITS = FRAC_BITS_DEF
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [log_w(FRAC_BITS)-1:0] i_LOG,
  input  logic                        i_VALID,
  output logic                        o_READY,
  output logic [OUT_W-1:0]            o_WORD,
  output logic                        o_VALID,
  input  logic                        i_READY
);
  localparam int DW = dp_w(FRAC_BITS);
  logic          en;
  logic          v_a, v_b;
  logic [DW-1:0] mant_in, mant_a, mant_b;
  logic [1:0]    k_a_q;
  logic          k_b_q;
  assign en = ~o_VALID | i_READY;
  assign o_READY = en;
  assign mant_in = DW'({1'b1, i_LOG[FRAC_BITS-1:0]});
  // remaining exponent bits travel alongside the mantissa, gated like the data registers
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      k_a_q <= '0;
      k_b_q <= 1'b0;
    end else if (en) begin
      if (i_VALID) k_a_q <= i_LOG[FRAC_BITS+1:FRAC_BITS];
      if (v_a) k_b_q <= k_a_q[0];
    end
  antilog2_shift_stage #(.IW(DW), .OW(DW), .SHIFT(4), .LSB(0)) u_a (
    .clk(clk), .reset_n(reset_n), .en_i(en), .v_i(i_VALID), .sel_i(i_LOG[FRAC_BITS+2]),
    .mant_i(mant_in), .v_o(v_a), .mant_o(mant_a)
  );
  antilog2_shift_stage #(.IW(DW), .OW(DW), .SHIFT(2), .LSB(0)) u_b (
    .clk(clk), .reset_n(reset_n), .en_i(en), .v_i(v_a), .sel_i(k_a_q[1]),
    .mant_i(mant_a), .v_o(v_b), .mant_o(mant_b)
  );
  antilog2_shift_stage #(.IW(DW), .OW(OUT_W), .SHIFT(1), .LSB(FRAC_BITS)) u_c (
    .clk(clk), .reset_n(reset_n), .en_i(en), .v_i(v_b), .sel_i(k_b_q),
    .mant_i(mant_b), .v_o(o_VALID), .mant_o(o_WORD)
  );
endmodule

// File: tb/tb_antilog2_fixed_point.sv
// tb_antilog2_fixed_point: directed table, sweep, stall, random, reset and toggle tests against an arithmetic model
module tb_antilog2_fixed_point;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [10:0] i_LOG = '0;
  logic        i_VALID = 1'b0;
  logic        o_READY;
  logic [7:0]  o_WORD;
  logic        o_VALID;
  logic        i_READY = 1'b0;

  int checks = 0;
  int errors = 0;
  int outs = 0;
  int sb[$];
  logic hold = 1'b0;
  logic [7:0] hold_w = '0;

  typedef struct {
    logic [10:0] log;
    int          word;
  } vec_t;
  vec_t tbl[4];

  antilog2_fixed_point #(.FRAC_BITS(8)) dut (
    .clk(clk), .reset_n(reset_n), .i_LOG(i_LOG), .i_VALID(i_VALID),
    .o_READY(o_READY), .o_WORD(o_WORD), .o_VALID(o_VALID), .i_READY(i_READY)
  );

  always #5 clk = ~clk;

  function automatic int model(input logic [10:0] l);
    int k = int'(l[10:8]);
    int f = int'(l[7:0]);
    return ((256 + f) * (1 << k)) / 256;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic v, input logic r, input logic [10:0] l);
    @(negedge clk);
    i_VALID = v;
    i_READY = r;
    i_LOG = l;
    #1;
    if (hold) begin
      chk("hold_valid", int'(o_VALID), 1);
      chk("hold_word", int'(o_WORD), int'(hold_w));
    end
    chk("ready", int'(o_READY), int'(!o_VALID || i_READY));
    if (o_VALID && i_READY) begin
      outs++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got %0d expected no output at %0t", o_WORD, $time);
      end else chk("word", int'(o_WORD), sb.pop_front());
    end
    if (i_VALID && o_READY) sb.push_back(model(i_LOG));
    hold = o_VALID && !i_READY;
    hold_w = o_WORD;
  endtask

  task automatic drain();
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, '0);
    chk("drained", sb.size(), 0);
  endtask

  initial begin
    tbl[0] = '{11'h000, 1};
    tbl[1] = '{11'h700, 128};
    tbl[2] = '{11'h380, 12};
    tbl[3] = '{11'h7FF, 255};
    #2;
    chk("rst_valid", int'(o_VALID), 0);
    chk("rst_word", int'(o_WORD), 0);
    chk("rst_ready", int'(o_READY), 1);
    @(negedge clk);
    reset_n = 1'b1;

    // directed back-to-back table with latency
    for (int t = 0; t < 7; t++) begin
      step(t < 4, 1'b1, t < 4 ? tbl[t].log : 11'h0);
      if (t < 3) chk("lat_idle", int'(o_VALID), 0);
      else begin
        chk("tbl_valid", int'(o_VALID), 1);
        chk("tbl_word", int'(o_WORD), tbl[t-3].word);
      end
    end
    drain();

    // exhaustive sweep
    outs = 0;
    for (int i = 0; i < 2048; i++) step(1'b1, 1'b1, 11'(i));
    drain();
    chk("sweep_count", outs, 2048);

    // stall with full pipe
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 11'($urandom_range(0, 2047)));
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 11'($urandom_range(0, 2047)));
      chk("stall_ready", int'(o_READY), 0);
    end
    chk("stall_queued", sb.size(), 3);
    outs = 0;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, '0);
    chk("stall_drain", outs, 3);
    drain();

    // random valid/ready
    for (int i = 0; i < 500; i++)
      step(1'(($urandom & 1)), 1'(($urandom & 1)), 11'($urandom_range(0, 2047)));
    drain();

    // toggling ready
    for (int i = 0; i < 12; i++) step(1'b1, 1'(i & 1), 11'($urandom_range(0, 2047)));
    drain();

    // asynchronous reset with three words in flight
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 11'($urandom_range(0, 2047)));
    @(posedge clk);
    #2;
    i_VALID = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("arst_valid", int'(o_VALID), 0);
    chk("arst_word", int'(o_WORD), 0);
    chk("arst_ready", int'(o_READY), 1);
    sb.delete();
    hold = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, '0);
      chk("post_rst_idle", int'(o_VALID), 0);
    end
    step(1'b1, 1'b1, 11'h5A3);
    step(1'b0, 1'b1, '0);
    chk("post_rst_lat1", int'(o_VALID), 0);
    step(1'b0, 1'b1, '0);
    chk("post_rst_lat2", int'(o_VALID), 0);
    step(1'b0, 1'b1, '0);
    chk("post_rst_lat3", int'(o_VALID), 1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
